// File: rtl/div_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | div_sequencer                                                           |
// | Buffers divide operands in a FIFO, sequences a fixed-latency divider    |
// | and holds each result until it is taken.                                |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module div_sequencer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_a,
    input  logic [4:0]  in_d,
    output logic [9:0]  div_ain,
    output logic [4:0]  div_din,
    output logic        div_start,
    output logic        div_finish,
    input  logic [5:0]  div_quo,
    input  logic [5:0]  div_rem,
    input  logic        div_divby0,
    input  logic        div_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_quo,
    output logic [5:0]  out_rem,
    output logic        out_divby0,
    output logic        out_overflow,
    output logic        busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(LAT);
    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LAT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_START  = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_FINISH = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;

    logic [14:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    logic [9:0]         r_ain;
    logic [4:0]         r_din;
    logic               r_out_valid;
    logic [5:0]         r_out_quo;
    logic [5:0]         r_out_rem;
    logic               r_out_divby0;
    logic               r_out_overflow;

    assign in_ready = (r_count != c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && in_ready;
    // The head entry leaves the FIFO during the LOAD cycle only.
    assign w_pop    = (r_state == c_LOAD);

    // Storage carries no reset; emptiness is defined by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_d};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (!w_empty) w_next = c_LOAD;
            c_LOAD:   w_next = c_START;
            c_START:  w_next = c_RUN;
            // A still-unclaimed result stalls completion with the count at zero.
            c_RUN:    if ((r_cnt == '0) && (!r_out_valid || out_ready)) w_next = c_FINISH;
            c_FINISH: w_next = w_empty ? c_IDLE : c_LOAD;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_ain <= '0;
            r_din <= '0;
        end else begin
            if (r_state == c_START) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == c_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (r_state == c_LOAD) begin
                {r_ain, r_din} <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid    <= 1'b0;
            r_out_quo      <= '0;
            r_out_rem      <= '0;
            r_out_divby0   <= 1'b0;
            r_out_overflow <= 1'b0;
        end else if (r_state == c_FINISH) begin
            r_out_valid    <= 1'b1;
            r_out_quo      <= div_quo;
            r_out_rem      <= div_rem;
            r_out_divby0   <= div_divby0;
            r_out_overflow <= div_overflow;
        end else if (r_out_valid && out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign div_ain      = r_ain;
    assign div_din      = r_din;
    assign div_start    = (r_state == c_START);
    assign div_finish   = (r_state == c_FINISH);
    assign busy         = (r_state != c_IDLE);
    assign out_valid    = r_out_valid;
    assign out_quo      = r_out_quo;
    assign out_rem      = r_out_rem;
    assign out_divby0   = r_out_divby0;
    assign out_overflow = r_out_overflow;

endmodule
`default_nettype wire
